fp_norm_round_pipe: RTL and testbench
=====================================

# fp_norm_round_pipe

Parametrised, pipelined normalize-and-round stage for the floating-point datapath. It takes the wide, un-normalised sum/product mantissa (carry, hidden bit, fraction and guard/round/sticky bits) with a biased exponent and sign. It produces a packed IEEE-754-style result with directed rounding and exception flags. It sits between the adder/multiplier core and the result register, uses a valid/ready handshake, and supports back-pressure.

## Interface
- EXP_W, 8, exponent width in bits.
- MAN_W, 23, stored fraction width in bits (hidden bit excluded).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W  biased exponent, unsigned.
- in_mant  in  MAN_W+5  {carry, hidden, fraction[MAN_W-1:0], guard, round, sticky}.
- rnd_mode  in  2  rounding mode, sampled with the beat: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  1+EXP_W+MAN_W  {sign, exp, fraction}.
- out_ovf, out_unf, out_inexact  out  1 each  overflow, underflow, inexact flags, aligned with out_result.

## Operation
- Three register stages (S1, S2, S3). Each stage holds a valid bit and the data/mode for its beat.
- S1 (capture + LZC):
  - Register the inputs.
  - Compute the shift code: carry set → right 1; else leading-zero count from the hidden position; all mantissa bits zero → zero flag.
- S2 (shift + exponent):
  - Right 1: mantissa >> 1; the shifted-out bit ORs into sticky; exp+1.
  - Left n: mantissa << n, zero-filled; exp−n.
  - Exponent arithmetic is signed, EXP_W+2 bits wide.
- S3 (round + pack):
  - Increment decision from guard/round/sticky, fraction LSB, sign and mode:
    - RNE: G && (R||S||LSB).
    - RTZ: never increment.
    - +inf: (G||R||S) && !sign.
    - −inf: (G||R||S) && sign.
  - Rounding carry out of the hidden bit: mantissa becomes 1.0, exp+1.
  - inexact = G||R||S after the shift.
- Exceptions, evaluated after rounding:
  - Zero input: result is ±0 with the sign kept, exp 0, fraction 0; all flags 0.
  - Final exp ≤ 0: flush to ±0, unf=1, inexact=1. No subnormals are produced.
  - Final exp ≥ 2^EXP_W−1: ovf=1, inexact=1. Result is ±inf for RNE, or for a directed mode rounding away from zero. Otherwise it is the max finite value (exp 2^EXP_W−2, fraction all ones).
- Handshake:
  - Pipeline-wide enable: en = !out_valid || out_ready; in_ready = en.
  - Transfer occurs on in_valid && in_ready.
  - When en=1 all stages advance. A bubble enters S1 when in_valid=0.
  - Bubbles do not collapse while stalled.
  - out_* are held stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync-released internally by the system): all stage valid bits 0, all data registers 0. So out_valid=0, out_result=0, all flags 0, in_ready=1.
- Latency: 3 cycles from the accepting edge to out_valid, with no stalls. Throughput: one beat per cycle.
- in_ready depends combinationally on out_ready and out_valid. There is no other input-to-output combinational path.
- Reset asserted mid-stream: all in-flight beats are discarded and outputs return to reset values immediately.
- rnd_mode changing between beats affects only beats accepted afterwards.

## Test plan
- EXP_W=8/MAN_W=23, RNE, sign 0, in_exp=0x7F, in_mant=28'hC000000 (carry) → 3 cycles later out_result=0x40400000, all flags 0.
- in_exp=0x85, in_mant=28'h0400000 (4 leading zeros) → 0x40800000. Then in_mant=0, sign 1 → 0x80000000, flags 0.
- Tie: in_exp=0x7F, in_mant={0,1,23'h000001,3'b100}:
  - RNE → 0x3F800002, inexact=1.
  - RTZ → 0x3F800001, inexact=1.
  - −inf with sign 1 → 0xBF800002.
- Overflow: in_exp=0xFE, carry set, RNE → 0x7F800000, ovf=1, inexact=1. Same input under RTZ → 0x7F7FFFFF.
- Underflow: in_exp=0x02, in_mant=28'h0200000 → 0x00000000, unf=1, inexact=1.
- Back-pressure: out_ready=0, in_valid=1 with 5 beats queued → exactly 3 accepted, in_ready=0, out_result stable. Raise out_ready → remaining beats drain in order, one per cycle. Pulse rst_n low mid-drain → out_valid=0 immediately.

Source files
------------

// File: rtl/fp_norm_round_pipe_if.sv
// ---------------------------------------------------------------------------
// fp_norm_round_pipe_if
// Handshake/data bundle for the normalize-and-round stage.
//   Input side : in_valid, in_ready, in_sign, in_exp, in_mant, rnd_mode
//   Output side: out_valid, out_ready, out_result, out_ovf, out_unf, out_inexact
// Modports:
//   master - producer/consumer around the stage (drives inputs, accepts results)
//   slave  - the stage itself
// ---------------------------------------------------------------------------
interface fp_norm_round_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sign;
    logic [EXP_W-1:0]       in_exp;
    logic [MAN_W+4:0]       in_mant;      // {carry, hidden, fraction, G, R, S}
    logic [1:0]             rnd_mode;     // 00 RNE, 01 RTZ, 10 +inf, 11 -inf
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   out_result;   // {sign, exp, fraction}
    logic                   out_ovf;
    logic                   out_unf;
    logic                   out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, rnd_mode, out_ready,
        input  in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, rnd_mode, out_ready,
        output in_ready, out_valid, out_result, out_ovf, out_unf, out_inexact
    );
endinterface

// File: rtl/fp_norm_round_pipe.sv
// ---------------------------------------------------------------------------
// fp_norm_round_pipe
// Three-stage normalize-and-round stage for the floating-point datapath.
//   S1: capture beat, compute shift code (carry -> right 1, else LZC, zero)
//   S2: apply shift, adjust exponent (signed, EXP_W+2 bits)
//   S3: directed rounding, exception handling, pack {sign, exp, fraction}
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - fp_norm_round_pipe_if.slave (valid/ready in, valid/ready out)
// A single pipeline-wide enable (en = !out_valid || out_ready) advances all
// stages together, so bubbles are preserved while stalled and the output
// registers hold steady under back-pressure.
// ---------------------------------------------------------------------------
module fp_norm_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp_norm_round_pipe_if.slave   bus
);
    localparam int MW  = MAN_W + 5;          // full input mantissa width
    localparam int EW2 = EXP_W + 2;          // signed working exponent width
    localparam int LW  = $clog2(MW) + 1;     // leading-zero count width

    localparam logic signed [EW2-1:0] EXP_ONE = 1;
    localparam logic signed [EW2-1:0] EXP_INF = EW2'((1 << EXP_W) - 1);

    // Leading-zero count from the hidden position down to sticky.
    // An all-zero field yields MW-1 (the zero flag overrides it anyway).
    function automatic logic [LW-1:0] lzc_f(input logic [MW-2:0] m);
        lzc_f = LW'(MW - 1);
        for (int i = 0; i <= MW - 2; i++) begin
            if (m[i]) lzc_f = LW'(MW - 2 - i);
        end
    endfunction

    logic w_en;
    assign w_en         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    // ---------------- S1: capture + shift code ----------------
    logic                 r_s1_valid;
    logic                 r_s1_sign;
    logic [EXP_W-1:0]     r_s1_exp;
    logic [MW-1:0]        r_s1_mant;
    logic [1:0]           r_s1_mode;
    logic [LW-1:0]        r_s1_lzc;
    logic                 r_s1_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_mant  <= '0;
            r_s1_mode  <= '0;
            r_s1_lzc   <= '0;
            r_s1_zero  <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign  <= bus.in_sign;
                r_s1_exp   <= bus.in_exp;
                r_s1_mant  <= bus.in_mant;
                r_s1_mode  <= bus.rnd_mode;
                r_s1_lzc   <= lzc_f(bus.in_mant[MW-2:0]);
                r_s1_zero  <= ~|bus.in_mant;
            end
        end
    end

    // ---------------- S2: shift + exponent ----------------
    // After normalisation the carry position is always clear, so S2 keeps
    // only {hidden, fraction, G, R, S}.
    logic [MW-2:0]          w_s2_mant;
    logic signed [EW2-1:0]  w_s2_exp;

    always_comb begin
        if (r_s1_mant[MW-1]) begin
            // Right by one: bit shifted out of sticky folds back into sticky.
            w_s2_mant = {r_s1_mant[MW-1:2], r_s1_mant[1] | r_s1_mant[0]};
            w_s2_exp  = $signed({2'b00, r_s1_exp}) + EXP_ONE;
        end else begin
            w_s2_mant = r_s1_mant[MW-2:0] << r_s1_lzc;
            w_s2_exp  = $signed({2'b00, r_s1_exp}) - $signed(EW2'(r_s1_lzc));
        end
    end

    logic                   r_s2_valid;
    logic                   r_s2_sign;
    logic signed [EW2-1:0]  r_s2_exp;
    logic [MW-2:0]          r_s2_mant;
    logic [1:0]             r_s2_mode;
    logic                   r_s2_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_mant  <= '0;
            r_s2_mode  <= '0;
            r_s2_zero  <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_exp  <= w_s2_exp;
                r_s2_mant <= w_s2_mant;
                r_s2_mode <= r_s1_mode;
                r_s2_zero <= r_s1_zero;
            end
        end
    end

    // ---------------- S3: round + exceptions + pack ----------------
    logic                   w_g, w_r, w_s, w_lsb, w_any;
    logic                   w_inc;
    logic                   w_rc;
    logic                   w_away;
    logic [MAN_W-1:0]       w_frac;
    logic signed [EW2-1:0]  w_exp_rnd;
    logic [EXP_W+MAN_W:0]   w_res;
    logic                   w_ovf, w_unf, w_inx;

    assign w_g   = r_s2_mant[2];
    assign w_r   = r_s2_mant[1];
    assign w_s   = r_s2_mant[0];
    assign w_lsb = r_s2_mant[3];
    assign w_any = w_g | w_r | w_s;

    always_comb begin
        w_inc = 1'b0;
        case (r_s2_mode)
            2'b00:   w_inc = w_g && (w_r || w_s || w_lsb);
            2'b01:   w_inc = 1'b0;
            2'b10:   w_inc = w_any && !r_s2_sign;
            default: w_inc = w_any && r_s2_sign;
        endcase
    end

    // Fraction wraps to zero exactly when {hidden, fraction} is all ones
    // and rounds up; that is the carry out of the hidden bit.
    assign w_frac    = r_s2_mant[MW-3:3] + MAN_W'(w_inc);
    assign w_rc      = w_inc & (&r_s2_mant[MW-2:3]);
    assign w_exp_rnd = r_s2_exp + $signed(EW2'(w_rc));

    // Overflow saturates to infinity only when rounding heads away from zero.
    assign w_away = (r_s2_mode == 2'b00) ||
                    (r_s2_mode == 2'b10 && !r_s2_sign) ||
                    (r_s2_mode == 2'b11 &&  r_s2_sign);

    always_comb begin
        w_res = {r_s2_sign, w_exp_rnd[EXP_W-1:0], w_frac};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_inx = w_any;
        if (r_s2_zero) begin
            w_res = {r_s2_sign, {(EXP_W+MAN_W){1'b0}}};
            w_inx = 1'b0;
        end else if (w_exp_rnd < EXP_ONE) begin
            w_res = {r_s2_sign, {(EXP_W+MAN_W){1'b0}}};
            w_unf = 1'b1;
            w_inx = 1'b1;
        end else if (w_exp_rnd >= EXP_INF) begin
            w_ovf = 1'b1;
            w_inx = 1'b1;
            if (w_away)
                w_res = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else
                w_res = {r_s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end
    end

    logic                 r_out_valid;
    logic [EXP_W+MAN_W:0] r_out_result;
    logic                 r_out_ovf;
    logic                 r_out_unf;
    logic                 r_out_inexact;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_ovf     <= 1'b0;
            r_out_unf     <= 1'b0;
            r_out_inexact <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_result  <= w_res;
                r_out_ovf     <= w_ovf;
                r_out_unf     <= w_unf;
                r_out_inexact <= w_inx;
            end
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_result  = r_out_result;
    assign bus.out_ovf     = r_out_ovf;
    assign bus.out_unf     = r_out_unf;
    assign bus.out_inexact = r_out_inexact;

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_norm_round_pipe
// Directed cases, randomized traffic with random stalls against a numeric
// reference model, back-pressure and mid-stream reset for fp_norm_round_pipe
// (EXP_W=8, MAN_W=23).
// ---------------------------------------------------------------------------
module tb_fp_norm_round_pipe;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    fp_norm_round_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_norm_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [34:0] sb[$];   // {ovf, unf, inexact, result}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Numeric model: locate the leading one, keep 24 significant bits and
    // round the discarded remainder exactly against half an ulp.
    function automatic logic [34:0] model(input logic s, input logic [7:0] ei,
                                          input logic [27:0] m, input logic [1:0] md);
        int     p;
        int     e;
        longint mm, sig, rem, half;
        bit     inc, inx, away;
        if (m == 28'd0) return {3'b000, s, 31'd0};
        mm = 0;
        mm[27:0] = m;
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        e = int'(ei) + p - 26;
        if (p > 23) begin
            sig  = mm >> (p - 23);
            rem  = mm & ((longint'(1) << (p - 23)) - 1);
            half = longint'(1) << (p - 24);
        end else begin
            sig  = mm << (23 - p);
            rem  = 0;
            half = 1;
        end
        inx = (rem != 0);
        case (md)
            2'b00:   inc = (rem > half) || (rem == half && sig[0] == 1'b1);
            2'b01:   inc = 1'b0;
            2'b10:   inc = inx && !s;
            default: inc = inx && s;
        endcase
        if (inc) sig = sig + 1;
        if (sig == (longint'(1) << 24)) begin
            sig = longint'(1) << 23;
            e++;
        end
        if (e <= 0) return {3'b011, s, 31'd0};
        if (e >= 255) begin
            away = (md == 2'b00) || (md == 2'b10 && !s) || (md == 2'b11 && s);
            if (away) return {3'b101, s, 8'hFF, 23'd0};
            return {3'b101, s, 8'hFE, 23'h7FFFFF};
        end
        return {2'b00, inx, s, e[7:0], sig[22:0]};
    endfunction

    task automatic drive(input logic s, input logic [7:0] e, input logic [27:0] m, input logic [1:0] md);
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        bus.rnd_mode = md;
    endtask

    task automatic rand_beat();
        logic [27:0] m;
        logic [7:0]  e;
        case ($urandom % 4)
            0:       e = 8'($urandom_range(0, 255));
            1:       e = 8'($urandom_range(0, 5));
            2:       e = 8'($urandom_range(250, 255));
            default: e = 8'($urandom_range(120, 135));
        endcase
        m = 28'($urandom) >> $urandom_range(0, 27);
        if ($urandom % 4 == 0)  m[27] = 1'b1;
        if ($urandom % 8 == 0)  m[2:0] = 3'b100;
        if ($urandom % 16 == 0) m = 28'd0;
        drive(1'($urandom), e, m, 2'($urandom));
    endtask

    // One cycle: called at a falling edge with inputs already driven.
    task automatic step(output bit acc);
        logic [34:0] ex;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            $display("out result=%08h ovf=%0b unf=%0b inx=%0b",
                     bus.out_result, bus.out_ovf, bus.out_unf, bus.out_inexact);
            if (sb.size() == 0) begin
                chk("sb_extra_out", 64'(bus.out_valid), 64'd0);
            end else begin
                ex = sb.pop_front();
                chk("sb_res", 64'(bus.out_result), 64'(ex[31:0]));
                chk("sb_flags", 64'({bus.out_ovf, bus.out_unf, bus.out_inexact}), 64'(ex[34:32]));
            end
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) sb.push_back(model(bus.in_sign, bus.in_exp, bus.in_mant, bus.rnd_mode));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic s, input logic [7:0] e,
                            input logic [27:0] m, input logic [1:0] md,
                            input logic [31:0] er, input logic [2:0] ef);
        int lat;
        logic [34:0] mex;
        mex = model(s, e, m, md);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive(s, e, m, md);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        $display("dir %s result=%08h flags=%03b latency=%0d", tag, bus.out_result,
                 {bus.out_ovf, bus.out_unf, bus.out_inexact}, lat);
        chk({tag, "_lat"},   64'(lat), 64'd3);
        chk({tag, "_res"},   64'(bus.out_result), 64'(er));
        chk({tag, "_flags"}, 64'({bus.out_ovf, bus.out_unf, bus.out_inexact}), 64'(ef));
        chk({tag, "_model"}, 64'({bus.out_ovf, bus.out_unf, bus.out_inexact, bus.out_result}), 64'(mex));
    endtask

    logic        bs[5];
    logic [7:0]  be[5];
    logic [27:0] bm[5];
    logic [1:0]  bmd[5];

    initial begin
        bit          acc;
        int          idx;
        int          guard;
        bit          have_held;
        logic [31:0] held;
        logic [27:0] tie;
        logic [27:0] allones;

        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 8'd0, 28'd0, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_result", 64'(bus.out_result), 64'd0);
        chk("rst_flags", 64'({bus.out_ovf, bus.out_unf, bus.out_inexact}), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        tie     = {1'b0, 1'b1, 23'h000001, 3'b100};
        allones = {1'b0, 1'b1, 23'h7FFFFF, 3'b100};
        directed("carry",     1'b0, 8'h7F, 28'hC000000, 2'b00, 32'h40400000, 3'b000);
        directed("lzc4",      1'b0, 8'h85, 28'h0400000, 2'b00, 32'h40800000, 3'b000);
        directed("zero_neg",  1'b1, 8'h85, 28'h0000000, 2'b00, 32'h80000000, 3'b000);
        directed("tie_rne",   1'b0, 8'h7F, tie,         2'b00, 32'h3F800002, 3'b001);
        directed("tie_rtz",   1'b0, 8'h7F, tie,         2'b01, 32'h3F800001, 3'b001);
        directed("tie_minf",  1'b1, 8'h7F, tie,         2'b11, 32'hBF800002, 3'b001);
        directed("ovf_rne",   1'b0, 8'hFE, 28'hC000000, 2'b00, 32'h7F800000, 3'b101);
        directed("ovf_rtz",   1'b0, 8'hFE, 28'hC000000, 2'b01, 32'h7F7FFFFF, 3'b101);
        directed("ovf_pinf_neg", 1'b1, 8'hFE, 28'hC000000, 2'b10, 32'hFF7FFFFF, 3'b101);
        directed("unf",       1'b0, 8'h02, 28'h0200000, 2'b00, 32'h00000000, 3'b011);
        directed("rnd_carry", 1'b0, 8'h7F, allones,     2'b00, 32'h40000000, 3'b001);

        // Randomized traffic with random bubbles and stalls.
        @(negedge clk);
        for (int c = 0; c < 300; c++) begin
            rand_beat();
            bus.in_valid  = ($urandom % 4) != 0;
            bus.out_ready = ($urandom % 4) != 0;
            step(acc);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            step(acc);
            guard++;
        end
        chk("rand_drained", 64'(sb.size()), 64'd0);

        // Back-pressure: five queued beats, downstream stalled.
        for (int i = 0; i < 5; i++) begin
            bs[i]  = 1'($urandom);
            be[i]  = 8'($urandom_range(100, 150));
            bm[i]  = 28'($urandom) | 28'h4000000;
            bmd[i] = 2'($urandom);
        end
        bus.out_ready = 1'b0;
        idx = 0;
        have_held = 1'b0;
        held = '0;
        for (int c = 0; c < 6; c++) begin
            drive(bs[idx], be[idx], bm[idx], bmd[idx]);
            bus.in_valid = 1'b1;
            step(acc);
            if (acc) idx++;
            if (bus.out_valid) begin
                if (!have_held) begin
                    held = bus.out_result;
                    have_held = 1'b1;
                end else begin
                    chk("bp_stable", 64'(bus.out_result), 64'(held));
                end
            end
        end
        #1;
        chk("bp_accepted", 64'(idx), 64'd3);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        @(negedge clk);

        bus.out_ready = 1'b1;
        guard = 0;
        while (idx < 5 && guard < 20) begin
            drive(bs[idx], be[idx], bm[idx], bmd[idx]);
            bus.in_valid = 1'b1;
            step(acc);
            if (acc) idx++;
            guard++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd5);
        bus.in_valid = 1'b0;
        step(acc);

        // Reset in the middle of draining: outputs clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset pulse: out_valid=%0b result=%08h", bus.out_valid, bus.out_result);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_result", 64'(bus.out_result), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_out_valid", 64'(bus.out_valid), 64'd0);

        directed("after_rst", 1'b0, 8'h7F, 28'hC000000, 2'b00, 32'h40400000, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
